// File: rtl/ae_sensor_cfg_sched_if.sv
// Sensor register write handshake between the AE config scheduler and the SCCB master.
interface ae_sensor_cfg_sched_if;
  logic        cfg_req;
  logic [15:0] cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_ack;

  modport master (output cfg_req, cfg_addr, cfg_data, input cfg_ack);
  modport slave  (input cfg_req, cfg_addr, cfg_data, output cfg_ack);
endinterface

// File: rtl/ae_sensor_cfg_sched.sv
// AE exposure/gain -> sensor register burst scheduler, frame-aligned, with a settle window.
// Optional ack timeout: define AE_CFG_TIMEOUT_EN.
module ae_sensor_cfg_sched #(
  parameter int          SETTLE_FRAMES  = 2,
  parameter logic [15:0] INIT_EXP       = 16'h0400,
  parameter logic [15:0] INIT_GAIN      = 16'h0010,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ae_enable,
  input  logic                         ae_valid,
  input  logic [15:0]                  exposure_time,
  input  logic [15:0]                  exposure_gain,
  input  logic                         rgb_vsync,
  ae_sensor_cfg_sched_if.master        cfg,
  output logic                         busy,
  output logic [15:0]                  applied_exp,
  output logic [15:0]                  applied_gain,
  output logic [7:0]                   update_cnt,
  output logic                         cfg_err
);

  typedef enum logic [1:0] {IDLE, ARMED, WRITE, SETTLE} state_t;
  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;

  state_t      state, state_nxt;
  logic        vsync_d, vs_rise;
  logic        pending;
  logic [15:0] pend_exp, pend_gain, work_exp, work_gain, gain_clamped;
  logic [2:0]  idx;
  logic        req;
  logic [3:0]  settle_cnt;
  logic        ack_hs, same_vals, burst_go, skip_go, timeout;
  wr_t         wr;

  // Write table: group hold open, exposure, gain, hold close, launch.
  function automatic wr_t burst_entry(input logic [2:0] i, input logic [15:0] e, input logic [15:0] g);
    case (i)
      3'd0:    return '{16'h3212, 8'h00};
      3'd1:    return '{16'h3500, {4'h0, e[15:12]}};
      3'd2:    return '{16'h3501, e[11:4]};
      3'd3:    return '{16'h3502, {e[3:0], 4'h0}};
      3'd4:    return '{16'h350A, {6'h0, g[9:8]}};
      3'd5:    return '{16'h350B, g[7:0]};
      3'd6:    return '{16'h3212, 8'h10};
      default: return '{16'h3212, 8'hA0};
    endcase
  endfunction

  assign vs_rise      = rgb_vsync & ~vsync_d;
  assign gain_clamped = (exposure_gain > 16'h03FF) ? 16'h03FF : exposure_gain;
  assign ack_hs       = req & cfg.cfg_ack;
  assign same_vals    = (pend_exp == applied_exp) && (pend_gain == applied_gain);
  assign burst_go     = (state == ARMED) && ae_enable && vs_rise && !same_vals;
  assign skip_go      = (state == ARMED) && ae_enable && vs_rise && same_vals;

`ifdef AE_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  assign timeout = req & ~cfg.cfg_ack & (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (pending && ae_enable) state_nxt = ARMED;
      ARMED:  if (!ae_enable) state_nxt = IDLE;
              else if (vs_rise) state_nxt = same_vals ? IDLE : WRITE;
      WRITE:  if (timeout || (ack_hs && idx == 3'd7)) state_nxt = SETTLE;
      SETTLE: if (vs_rise && settle_cnt == 4'(SETTLE_FRAMES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr           = burst_entry(idx, work_exp, work_gain);
    busy         = (state != IDLE);
    cfg.cfg_req  = req;
    cfg.cfg_addr = (state == WRITE) ? wr.addr : 16'h0;
    cfg.cfg_data = (state == WRITE) ? wr.data : 8'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d      <= 1'b0;
      pending      <= 1'b0;
      pend_exp     <= '0;
      pend_gain    <= '0;
      work_exp     <= '0;
      work_gain    <= '0;
      idx          <= '0;
      req          <= 1'b0;
      settle_cnt   <= '0;
      applied_exp  <= INIT_EXP;
      applied_gain <= INIT_GAIN;
      update_cnt   <= '0;
`ifdef AE_CFG_TIMEOUT_EN
      to_cnt       <= '0;
      cfg_err      <= 1'b0;
`endif
    end else begin
      vsync_d <= rgb_vsync;
      if (burst_go || skip_go) pending <= 1'b0;
      if (burst_go) begin
        work_exp  <= pend_exp;
        work_gain <= pend_gain;
        idx       <= '0;
        req       <= 1'b1;
`ifdef AE_CFG_TIMEOUT_EN
        to_cnt    <= '0;
`endif
      end
      if (state == WRITE) begin
        if (timeout) begin
          // Abandoned burst: shadows and counter keep their old values.
          req        <= 1'b0;
          settle_cnt <= '0;
`ifdef AE_CFG_TIMEOUT_EN
          cfg_err    <= 1'b1;
`endif
        end else if (ack_hs) begin
          req <= 1'b0;
          if (idx == 3'd7) begin
            applied_exp  <= work_exp;
            applied_gain <= work_gain;
            update_cnt   <= update_cnt + 8'd1;
            settle_cnt   <= '0;
          end else begin
            idx <= idx + 3'd1;
          end
        end else if (!req) begin
          req <= 1'b1;
`ifdef AE_CFG_TIMEOUT_EN
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
`endif
        end
      end
      if (state == SETTLE && vs_rise) settle_cnt <= settle_cnt + 4'd1;
      // A pulse coinciding with a burst launch survives as the next pending update.
      if (ae_valid) begin
        pend_exp  <= exposure_time;
        pend_gain <= gain_clamped;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ae_sensor_cfg_sched.sv
// Bench for ae_sensor_cfg_sched: transaction-level model + directed literal pins + random traffic.
module tb_ae_sensor_cfg_sched;
  localparam int          SF        = 2;
  localparam logic [15:0] INIT_EXP  = 16'h0400;
  localparam logic [15:0] INIT_GAIN = 16'h0010;
  localparam int M_IDLE = 0, M_ARMED = 1, M_WRITE = 2, M_SETTLE = 3;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, valid = 1'b0, vsync = 1'b0;
  logic [15:0] exp_in = '0, gain_in = '0;
  logic busy, err;
  logic [15:0] app_e, app_g;
  logic [7:0]  ucnt;

  ae_sensor_cfg_sched_if cfg_if();

  ae_sensor_cfg_sched #(.SETTLE_FRAMES(SF), .INIT_EXP(INIT_EXP), .INIT_GAIN(INIT_GAIN)) dut (
    .clk(clk), .rst(rst), .ae_enable(en), .ae_valid(valid),
    .exposure_time(exp_in), .exposure_gain(gain_in), .rgb_vsync(vsync),
    .cfg(cfg_if), .busy(busy), .applied_exp(app_e), .applied_gain(app_g),
    .update_cnt(ucnt), .cfg_err(err));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode = M_IDLE, m_settle = 0;
  bit          m_pend = 0, m_req = 0, m_vsp = 0, m_rise;
  logic [15:0] m_pe = '0, m_pg = '0, m_we = '0, m_wg = '0, m_ae = INIT_EXP, m_ag = INIT_GAIN;
  logic [7:0]  m_cnt = '0;
  logic [23:0] m_q[$];
  logic [23:0] wlog[$];

  function automatic logic [15:0] clampg(input logic [15:0] g);
    return (g > 16'h03FF) ? 16'h03FF : g;
  endfunction

  task automatic load_burst(input logic [15:0] e, input logic [15:0] g);
    m_q.delete();
    m_q.push_back({16'h3212, 8'h00});
    m_q.push_back({16'h3500, 4'h0, e[15:12]});
    m_q.push_back({16'h3501, e[11:4]});
    m_q.push_back({16'h3502, e[3:0], 4'h0});
    m_q.push_back({16'h350A, 6'h0, g[9:8]});
    m_q.push_back({16'h350B, g[7:0]});
    m_q.push_back({16'h3212, 8'h10});
    m_q.push_back({16'h3212, 8'hA0});
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_pend = 0; m_req = 0; m_settle = 0; m_vsp = 0;
      m_ae = INIT_EXP; m_ag = INIT_GAIN; m_cnt = '0; m_q.delete();
    end else begin
      m_rise = vsync && !m_vsp;
      m_vsp  = vsync;
      case (m_mode)
        M_IDLE:  if (m_pend && en) m_mode = M_ARMED;
        M_ARMED: if (!en) m_mode = M_IDLE;
                 else if (m_rise) begin
                   if (m_pe == m_ae && m_pg == m_ag) m_mode = M_IDLE;
                   else begin
                     m_we = m_pe; m_wg = m_pg; load_burst(m_pe, m_pg);
                     m_req = 1; m_mode = M_WRITE;
                   end
                   m_pend = 0;
                 end
        M_WRITE: if (m_req && cfg_if.cfg_ack) begin
                   m_req = 0;
                   void'(m_q.pop_front());
                   if (m_q.size() == 0) begin
                     m_ae = m_we; m_ag = m_wg; m_cnt = m_cnt + 8'd1;
                     m_settle = 0; m_mode = M_SETTLE;
                   end
                 end else if (!m_req) m_req = 1;
        default: if (m_rise) begin
                   m_settle++;
                   if (m_settle == SF) m_mode = M_IDLE;
                 end
      endcase
      if (valid) begin m_pe = exp_in; m_pg = clampg(gain_in); m_pend = 1; end
    end
  end

  // Single compare process: DUT vs model every cycle, plus handshake log.
  always @(negedge clk) begin
    check("req",   32'(cfg_if.cfg_req), 32'(m_req));
    check("busy",  32'(busy), 32'(m_mode != M_IDLE));
    check("app_exp",  32'(app_e), 32'(m_ae));
    check("app_gain", 32'(app_g), 32'(m_ag));
    check("upd_cnt",  32'(ucnt), 32'(m_cnt));
    check("cfg_err",  32'(err), 32'(1'b0));
    if (m_req && m_q.size() > 0)
      check("addr_data", 32'({cfg_if.cfg_addr, cfg_if.cfg_data}), 32'(m_q[0]));
    if (!rst && cfg_if.cfg_req && cfg_if.cfg_ack)
      wlog.push_back({cfg_if.cfg_addr, cfg_if.cfg_data});
  end

  // ---------------- ack responder ----------------
  int ack_dly = 0, cur_dly = 0, wcnt = 0;
  bit ack_rand = 0, spur = 0;
  always begin
    cfg_if.cfg_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cfg_if.cfg_req && !rst) begin
        if (wcnt >= cur_dly) begin cfg_if.cfg_ack = 1'b1; wcnt = 0; end
        else begin cfg_if.cfg_ack = 1'b0; wcnt++; end
      end else begin
        wcnt = 0;
        cur_dly = ack_rand ? int'($urandom_range(0, 4)) : ack_dly;
        cfg_if.cfg_ack = spur && ($urandom_range(0, 5) == 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic pulse_valid(input logic [15:0] e, input logic [15:0] g);
    exp_in = e; gain_in = g; valid = 1'b1; tick(); valid = 1'b0;
  endtask
  task automatic vpulse();
    vsync = 1'b1; tick(3); vsync = 1'b0; tick(6);
  endtask
  task automatic wait_cnt(input logic [7:0] tgt);
    int k = 0;
    while (ucnt !== tgt && k < 600) begin tick(); k++; end
    check("burst_done", 32'(ucnt), 32'(tgt));
  endtask
  task automatic check_log(input int base, input int i, input logic [23:0] expv);
    if (base + i < wlog.size()) check($sformatf("log[%0d]", i), 32'(wlog[base+i]), 32'(expv));
    else check("log_len", wlog.size(), base + i + 1);
  endtask

  logic [23:0] burst1 [8] = '{24'h321200, 24'h350001, 24'h350123, 24'h350240,
                              24'h350A00, 24'h350B50, 24'h321210, 24'h3212A0};
  int base;

  initial begin
    tick(3); rst = 1'b0;
    check("rst_req", 32'(cfg_if.cfg_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_exp", 32'(app_e), 32'h0400);
    check("rst_gain", 32'(app_g), 32'h0010);
    check("rst_cnt", 32'(ucnt), 0);

    // Basic burst
    en = 1'b1;
    base = wlog.size();
    pulse_valid(16'h1234, 16'h0050); tick(); vpulse(); wait_cnt(8'd1);
    for (int i = 0; i < 8; i++) check_log(base, i, burst1[i]);
    check("b1_exp", 32'(app_e), 32'h1234);
    check("b1_gain", 32'(app_g), 32'h0050);
    vpulse(); vpulse();

    // Gain clamp
    base = wlog.size();
    pulse_valid(16'h1234, 16'h0FFF); tick(); vpulse(); wait_cnt(8'd2);
    check_log(base, 4, 24'h350A03);
    check_log(base, 5, 24'h350BFF);
    check("clamp_gain", 32'(app_g), 32'h03FF);
    vpulse(); vpulse();

    // Unchanged values: no writes
    base = wlog.size();
    pulse_valid(16'h1234, 16'h0FFF); tick(); vpulse(); tick(3);
    check("noop_len", wlog.size(), base);
    check("noop_cnt", 32'(ucnt), 2);
    check("noop_busy", 32'(busy), 0);

    // Slow acks, updates arriving during settle
    ack_dly = 5;
    pulse_valid(16'h0100, 16'h0020); tick(); vpulse(); wait_cnt(8'd3);
    base = wlog.size();
    pulse_valid(16'h0200, 16'h0020); tick(2); pulse_valid(16'h0300, 16'h0020);
    vpulse();
    check("settle1_busy", 32'(busy), 1);
    check("settle1_len", wlog.size(), base);
    vpulse();
    check("settle2_len", wlog.size(), base);
    vpulse(); wait_cnt(8'd4);
    check("settle_exp", 32'(app_e), 32'h0300);
    check_log(base, 1, 24'h350000);
    check_log(base, 2, 24'h350130);
    vpulse(); vpulse();

    // ae_valid coincident with the arming edge
    ack_dly = 0;
    pulse_valid(16'h0500, 16'h0040); tick(2);
    exp_in = 16'h0600; gain_in = 16'h0060; valid = 1'b1; vsync = 1'b1;
    tick(); valid = 1'b0; tick(2); vsync = 1'b0;
    wait_cnt(8'd5);
    check("coin_old", 32'(app_e), 32'h0500);
    vpulse(); vpulse(); vpulse(); wait_cnt(8'd6);
    check("coin_new_e", 32'(app_e), 32'h0600);
    check("coin_new_g", 32'(app_g), 32'h0060);
    vpulse(); vpulse();

    // Reset in the middle of a burst
    ack_dly = 2;
    pulse_valid(16'h0700, 16'h0070); tick(); vsync = 1'b1;
    for (int k = 0; k < 100 && !(cfg_if.cfg_req && cfg_if.cfg_addr == 16'h3502); k++) tick();
    check("reach_idx3", 32'(cfg_if.cfg_addr), 32'h3502);
    rst = 1'b1; tick();
    check("mid_rst_req", 32'(cfg_if.cfg_req), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_exp", 32'(app_e), 32'(INIT_EXP));
    check("mid_rst_gain", 32'(app_g), 32'(INIT_GAIN));
    vsync = 1'b0; tick(); rst = 1'b0; tick();

    // Reset values requested again: no writes
    base = wlog.size();
    pulse_valid(INIT_EXP, INIT_GAIN); tick(); vpulse(); tick(3);
    check("init_noop_len", wlog.size(), base);
    check("init_noop_cnt", 32'(ucnt), 0);

    // Random traffic
    ack_rand = 1; spur = 1;
    begin
      int per = 30, ph = 0;
      for (int c = 0; c < 8000; c++) begin
        if ($urandom_range(0, 59) == 0) en = ~en;
        if ($urandom_range(0, 24) == 0) begin
          exp_in  = 16'($urandom_range(0, 3)) * 16'h0100 + 16'h0100;
          case ($urandom_range(0, 3))
            0: gain_in = 16'h0010;
            1: gain_in = 16'h0FFF;
            2: gain_in = 16'h03FF;
            default: gain_in = 16'($urandom);
          endcase
          valid = 1'b1;
        end else valid = 1'b0;
        vsync = (ph < 3);
        ph++;
        if (ph >= per) begin ph = 0; per = $urandom_range(15, 60); end
        tick();
      end
      valid = 1'b0; vsync = 1'b0;
      tick(5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
